// File: rtl/lsu.sv
// lsu: RV32I load/store unit issuing one word-aligned transaction on a req/gnt/rvalid port.
// Define LSU_TIMEOUT_EN to abort a transaction with o_bus_err after MAX_WAIT cycles in REQ+WAIT.
module lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_misalign,
  output logic        o_bus_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t      state;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic [4:0]  ld_rd;
  logic        op_illegal, op_misal;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;
  logic        abort;

  assign o_ready = (state == IDLE);

  // funct3[1:0] encodes the access size for every legal load and store
  always_comb begin
    op_illegal = i_we ? (i_funct3 > 3'b010)
                      : (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11);
    op_misal   = 1'b0;
    be_n       = 4'b1111;
    wdata_n    = i_wdata;
    case (i_funct3[1:0])
      2'b01:   op_misal = i_addr[0];
      2'b10:   op_misal = |i_addr[1:0];
      default: ;
    endcase
    if (i_we) begin
      case (i_funct3[1:0])
        2'b00: begin
          be_n    = 4'b0001 << i_addr[1:0];
          wdata_n = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          be_n    = i_addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{i_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_byte = i_mem_rdata[{ld_off, 3'b000} +: 8];
    rd_half = ld_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (ld_f3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = i_mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] wait_cnt;
  // a response arriving in the final WAIT cycle still completes normally
  assign abort = (wait_cnt == 8'(MAX_WAIT - 1)) &&
                 (state == REQ || (state == WAIT && !i_mem_rvalid));
`else
  logic unused_cfg;
  assign abort      = 1'b0;
  assign unused_cfg = ^32'(MAX_WAIT);
  assign o_bus_err  = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
      o_wb_valid  <= 1'b0;
      o_wb_rd     <= '0;
      o_wb_data   <= '0;
      o_misalign  <= 1'b0;
      ld_f3       <= '0;
      ld_off      <= '0;
      ld_rd       <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt    <= '0;
      o_bus_err   <= 1'b0;
`endif
    end else begin
      o_wb_valid <= 1'b0;
      o_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      o_bus_err  <= abort;
      if (state != IDLE) wait_cnt <= wait_cnt + 8'd1;
`endif
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (op_illegal || op_misal) begin
              o_misalign <= 1'b1;
            end else begin
              state       <= REQ;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_we;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_be    <= be_n;
              o_mem_wdata <= wdata_n;
              ld_f3       <= i_funct3;
              ld_off      <= i_addr[1:0];
              ld_rd       <= i_rd;
`ifdef LSU_TIMEOUT_EN
              wait_cnt    <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (abort) begin
            state     <= IDLE;
            o_mem_req <= 1'b0;
          end else if (i_mem_gnt) begin
            state     <= WAIT;
            o_mem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            state <= IDLE;
            if (!o_mem_we && ld_rd != 5'd0) begin
              o_wb_valid <= 1'b1;
              o_wb_rd    <= ld_rd;
              o_wb_data  <= ld_data;
            end
          end else if (abort) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vectors against a transaction-level model of the LSU, checked every cycle.
module tb_lsu;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0, i_we = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic [4:0]  i_rd = '0;
  logic        i_mem_gnt = 1'b0, i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_ready, o_mem_req, o_mem_we, o_wb_valid, o_misalign, o_bus_err;
  logic [31:0] o_mem_addr, o_mem_wdata, o_wb_data;
  logic [3:0]  o_mem_be;
  logic [4:0]  o_wb_rd;

  always #5 i_clk = ~i_clk;

  lsu #(.MAX_WAIT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_wb_valid(o_wb_valid),
    .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_misalign(o_misalign), .o_bus_err(o_bus_err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic        chk_en = 1'b0;
  logic        exp_ready = 1'b1, exp_req = 1'b0, exp_we = 1'b0;
  logic        exp_wb = 1'b0, exp_mis = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_wbdata = '0;
  logic [3:0]  exp_be = '0;
  logic [4:0]  exp_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: access size, legality, lane placement and extension from plain arithmetic
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (we && f3 > 3'd2) return 1'b0;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
    return (int'(a[1:0]) % nbytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!we) return 4'hF;
    return 4'(((1 << nbytes(f3)) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n = nbytes(f3);
    r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [63:0] mask;
    logic [31:0] v;
    int n = nbytes(f3);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = (rd >> (8 * int'(a[1:0]))) & mask[31:0];
    if (!f3[2] && v[8*n-1]) v = v | ~mask[31:0];
    return v;
  endfunction

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("ready", 32'(o_ready), 32'(exp_ready));
      chk("mem_req", 32'(o_mem_req), 32'(exp_req));
      chk("wb_valid", 32'(o_wb_valid), 32'(exp_wb));
      chk("misalign", 32'(o_misalign), 32'(exp_mis));
      chk("bus_err", 32'(o_bus_err), 32'(exp_err));
      if (exp_req) begin
        chk("mem_addr", o_mem_addr, exp_addr);
        chk("mem_we", 32'(o_mem_we), 32'(exp_we));
        chk("mem_be", 32'(o_mem_be), 32'(exp_be));
        if (exp_we) chk("mem_wdata", o_mem_wdata, exp_wdata);
      end
      if (exp_wb) begin
        chk("wb_rd", 32'(o_wb_rd), 32'(exp_rd));
        chk("wb_data", o_wb_data, exp_wbdata);
      end
    end
  end

  task automatic cyc;
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_idle;
    exp_ready = 1'b1; exp_req = 1'b0; exp_wb = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
  endtask

  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
    set_idle();
    i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd; i_rd = rd;
    cyc();
    i_valid = 1'b0; i_addr = $urandom(); i_wdata = $urandom(); i_funct3 = 3'($urandom());
  endtask

  // gw/rw: extra cycles before gnt/rvalid; lit_w is store data (stores) or wb data (loads)
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int gw,
                        input int rw, input logic [31:0] rdat, input bit stray,
                        input bit lit_en, input logic [3:0] lit_be, input logic [31:0] lit_w);
    present(we, f3, a, wd, rd);
    if (!m_legal(we, f3, a)) begin
      exp_mis = 1'b1;
      cyc();
      exp_mis = 1'b0;
      cyc();
      return;
    end
    exp_ready = 1'b0; exp_req = 1'b1; exp_we = we; exp_addr = {a[31:2], 2'b00};
    exp_be = m_be(we, f3, a); exp_wdata = m_wdata(f3, wd);
    for (int i = 0; i <= gw; i++) begin
      i_mem_gnt = (i == gw);
      i_mem_rvalid = stray && (i == 0);
      i_mem_rdata = $urandom();
      if (i == 0 && lit_en) begin
        @(negedge i_clk);
        chk("lit_be", 32'(o_mem_be), 32'(lit_be));
        if (we) chk("lit_wdata", o_mem_wdata, lit_w);
      end
      cyc();
    end
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; exp_req = 1'b0;
    for (int i = 0; i <= rw; i++) begin
      i_mem_rvalid = (i == rw);
      i_mem_rdata = (i == rw) ? rdat : $urandom();
      cyc();
    end
    i_mem_rvalid = 1'b0;
    exp_ready = 1'b1; exp_wb = !we && rd != 5'd0; exp_rd = rd; exp_wbdata = m_load(f3, a, rdat);
    if (lit_en && !we) begin
      @(negedge i_clk);
      chk("lit_wb_data", o_wb_data, lit_w);
    end
    cyc();
    set_idle();
  endtask

  task automatic reset_mid(input bit in_wait);
    present(1'b0, 3'b010, 32'h0000_B000, 32'h0, 5'd9);
    exp_ready = 1'b0; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_B000; exp_be = 4'hF;
    if (in_wait) begin
      i_mem_gnt = 1'b1;
      cyc();
      i_mem_gnt = 1'b0; exp_req = 1'b0;
    end
    #1;
    chk_en = 1'b0;
    chk("pre_rst_req", 32'(o_mem_req), 32'(!in_wait));
    i_rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    #1;
    i_rst_n = 1'b1;
    set_idle();
    cyc();
    chk_en = 1'b1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_AAAA;
    cyc();
    i_mem_rvalid = 1'b0;
    cyc();
  endtask

  initial begin
    #2;
    chk("rst_ready0", 32'(o_ready), 32'd1);
    chk("rst_req0", 32'(o_mem_req), 32'd0);
    chk("rst_addr0", o_mem_addr, 32'd0);
    chk("rst_be0", 32'(o_mem_be), 32'd0);
    chk("rst_wdata0", o_mem_wdata, 32'd0);
    chk("rst_wb0", 32'(o_wb_valid), 32'd0);
    chk("rst_wbdata0", o_wb_data, 32'd0);
    chk("rst_mis0", 32'(o_misalign), 32'd0);
    chk("rst_err0", 32'(o_bus_err), 32'd0);
    #20;
    i_rst_n = 1'b1;
    cyc();
    chk_en = 1'b1;

    //     we    f3      addr          wdata         rd  gw rw rdata        stray lit be     lit value
    run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0,        5,  0, 0, 32'h80FF_FF7F, 0, 1, 4'hF,  32'hFFFF_FF80);
    run_op(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 0, 32'h0,         0, 1, 4'hC,  32'hBEEF_BEEF);
    run_op(1'b0, 3'b010, 32'h0000_3001, 32'h0,        3,  0, 0, 32'h0,         0, 0, 4'h0,  32'h0);
    run_op(1'b0, 3'b101, 32'h0000_4002, 32'h0,        12, 3, 0, 32'hABCD_1234, 1, 1, 4'hF,  32'h0000_ABCD);
    run_op(1'b1, 3'b000, 32'h0000_5001, 32'h1234_5678, 0, 1, 1, 32'h0,         1, 1, 4'h2,  32'h7878_7878);
    run_op(1'b0, 3'b001, 32'h0000_6000, 32'h0,        31, 0, 2, 32'h0000_8001, 0, 1, 4'hF,  32'hFFFF_8001);
    run_op(1'b0, 3'b100, 32'h0000_7002, 32'h0,        17, 0, 0, 32'h00A5_0000, 0, 1, 4'hF,  32'h0000_00A5);
    run_op(1'b0, 3'b010, 32'h0000_8000, 32'h0,        0,  0, 0, 32'hCAFE_F00D, 0, 0, 4'h0,  32'h0);
    run_op(1'b1, 3'b010, 32'h0000_9004, 32'hDEAD_BEEF, 0, 2, 0, 32'h0,         0, 1, 4'hF,  32'hDEAD_BEEF);
    run_op(1'b1, 3'b001, 32'h0000_9006, 32'h0000_1234, 0, 0, 0, 32'h0,         0, 1, 4'h3 << 2, 32'h1234_1234);
    run_op(1'b0, 3'b011, 32'h0000_A000, 32'h0,        4,  0, 0, 32'h0,         0, 0, 4'h0,  32'h0);
    run_op(1'b1, 3'b100, 32'h0000_A000, 32'h0,        0,  0, 0, 32'h0,         0, 0, 4'h0,  32'h0);
    run_op(1'b1, 3'b001, 32'h0000_A001, 32'h0,        0,  0, 0, 32'h0,         0, 0, 4'h0,  32'h0);
    run_op(1'b0, 3'b001, 32'h0000_A003, 32'h0,        6,  0, 0, 32'h0,         0, 0, 4'h0,  32'h0);
    run_op(1'b0, 3'b000, 32'h0000_B001, 32'h0,        8,  0, 0, 32'h0000_8000, 0, 1, 4'hF,  32'hFFFF_FF80);

`ifdef LSU_TIMEOUT_EN
    present(1'b0, 3'b010, 32'h0000_C000, 32'h0, 5'd7);
    exp_ready = 1'b0; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_C000; exp_be = 4'hF;
    repeat (4) cyc();
    exp_ready = 1'b1; exp_req = 1'b0; exp_err = 1'b1;
    cyc();
    exp_err = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678;
    cyc();
    i_mem_rvalid = 1'b0;
    cyc();
`endif

    reset_mid(1'b0);
    reset_mid(1'b1);
    run_op(1'b0, 3'b010, 32'h0000_D008, 32'h0, 2, 0, 0, 32'h0BAD_CAFE, 0, 1, 4'hF, 32'h0BAD_CAFE);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
